hbridge_chopper: RTL and testbench

Current-regulating H-bridge gate driver for one motor coil. Takes a signed target current and the measured signed coil current, and generates the four half-bridge gate signals (high_1, low_1, high_2, low_2). It uses fixed-off-time chopping with dead-time insertion and leading-edge blanking. It sits between the microstepping/current-table logic and the power stage, or the hbridge_coil model in simulation.

---
 rtl/hbridge_chopper.sv | 178 +++++++++++++++++
 tb/tb_hbridge_chopper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hbridge_chopper.sv
// Fixed-off-time current chopper for one H-bridge coil with dead-time insertion and leading-edge blanking.
// Define HBRIDGE_MIXED_DECAY_EN for a mixed off phase: fast decay first, then slow decay.
module hbridge_chopper #(
    parameter int DEADTIME    = 3,
    parameter int BLANK       = 8,
    parameter int TOFF        = 32,
    parameter int FAST_CYCLES = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic signed [12:0] target,
    input  logic signed [12:0] current,
    output logic               high_1,
    output logic               low_1,
    output logic               high_2,
    output logic               low_2,
    output logic               peak,
    output logic [2:0]         phase
);

    localparam int MAX_DB = (DEADTIME > BLANK) ? DEADTIME : BLANK;
    localparam int MAXC   = (MAX_DB > TOFF) ? MAX_DB : TOFF;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] CNT_MAX    = CW'(MAXC);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEADTIME - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] TOFF_LAST  = CW'(TOFF - 1);
    localparam logic [CW-1:0] FAST_LAST  = CW'(FAST_CYCLES - 1);

`ifdef HBRIDGE_MIXED_DECAY_EN
    localparam bit MIXED = 1'b1;
`else
    localparam bit MIXED = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEAD     = 3'd1,
        S_ON       = 3'd2,
        S_OFF_FAST = 3'd3,
        S_OFF_SLOW = 3'd4
    } state_t;

    localparam state_t OFF_ENTRY = MIXED ? S_OFF_FAST : S_OFF_SLOW;

    state_t        state, state_n;
    state_t        after_state, after_n;
    logic          dir, dir_n;
    logic          peak_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] toff;
    logic [3:0]    gates_n;

    logic target_nz;
    logic sign_flip;
    logic reached;
    logic active;

    assign target_nz = (target != 13'sd0);
    assign sign_flip = target_nz && (target[12] != dir);
    assign reached   = !target_nz || (dir ? (current <= target) : (current >= target));
    assign active    = (state == S_ON) || (state == S_OFF_FAST) || (state == S_OFF_SLOW);
    assign phase     = state;

    // A direction change requested while already in DEAD just retargets the pending state,
    // since the bridge is already off and the dead time in progress still covers it.
    always_comb begin
        state_n = state;
        after_n = after_state;
        dir_n   = dir;
        peak_n  = 1'b0;
        if (active && !enable) begin
            state_n = S_DEAD;
            after_n = S_IDLE;
        end else if (active && sign_flip) begin
            dir_n   = target[12];
            state_n = S_DEAD;
            after_n = S_ON;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && target_nz) begin
                        dir_n   = target[12];
                        state_n = S_DEAD;
                        after_n = S_ON;
                    end
                end
                S_DEAD: begin
                    if (!enable) begin
                        after_n = S_IDLE;
                    end else if (sign_flip) begin
                        dir_n   = target[12];
                        after_n = S_ON;
                    end
                    if (cnt >= DEAD_LAST) begin
                        state_n = after_n;
                    end
                end
                S_ON: begin
                    if (cnt >= BLANK_LAST && reached) begin
                        peak_n  = 1'b1;
                        state_n = S_DEAD;
                        after_n = OFF_ENTRY;
                    end
                end
                S_OFF_FAST: begin
                    if (toff >= FAST_LAST) begin
                        state_n = S_DEAD;
                        after_n = S_OFF_SLOW;
                    end
                end
                S_OFF_SLOW: begin
                    if (toff >= TOFF_LAST && target_nz) begin
                        state_n = S_DEAD;
                        after_n = S_ON;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    after_n = S_IDLE;
                end
            endcase
        end
    end

    // Gate pattern for the state being entered, ordered {high_1, low_1, high_2, low_2}.
    always_comb begin
        gates_n = 4'b0000;
        case (state_n)
            S_ON:       gates_n = dir_n ? 4'b0110 : 4'b1001;
            S_OFF_FAST: gates_n = dir_n ? 4'b1001 : 4'b0110;
            S_OFF_SLOW: gates_n = 4'b0101;
            default:    gates_n = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            after_state <= S_IDLE;
            dir         <= 1'b0;
            peak        <= 1'b0;
            high_1      <= 1'b0;
            low_1       <= 1'b0;
            high_2      <= 1'b0;
            low_2       <= 1'b0;
        end else begin
            state                        <= state_n;
            after_state                  <= after_n;
            dir                          <= dir_n;
            peak                         <= peak_n;
            {high_1, low_1, high_2, low_2} <= gates_n;
        end
    end

    // The off-time counter spans both decay states and skips DEAD, so it only clears
    // when a fresh ON phase starts or the bridge returns to IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            toff <= '0;
        end else begin
            if (state_n != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if ((state_n == S_ON && state != S_ON) || state_n == S_IDLE) begin
                toff <= '0;
            end else if ((state == S_OFF_FAST || state == S_OFF_SLOW) && toff != CNT_MAX) begin
                toff <= toff + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hbridge_chopper.sv
// Directed bench for hbridge_chopper: cycle-accurate vector table plus async-reset and
// gate-safety checks on every stepped cycle.
module tb_hbridge_chopper;

    logic               clk = 1'b0;
    logic               resetn;
    logic               enable;
    logic signed [12:0] target;
    logic signed [12:0] current;
    logic               high_1, low_1, high_2, low_2;
    logic               peak;
    logic [2:0]         phase;

    int vectors     = 0;
    int miscompares = 0;
    int zero_run    = 100;
    logic [3:0] last_nz = 4'b0000;

    localparam logic [3:0] G0  = 4'b0000;
    localparam logic [3:0] FWD = 4'b1001;
    localparam logic [3:0] REV = 4'b0110;
    localparam logic [3:0] SLW = 4'b0101;

    always #5 clk = ~clk;

    hbridge_chopper #(
        .DEADTIME(3), .BLANK(8), .TOFF(32), .FAST_CYCLES(8)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .target(target), .current(current),
        .high_1(high_1), .low_1(low_1), .high_2(high_2), .low_2(low_2),
        .peak(peak), .phase(phase)
    );

    typedef struct {
        logic               en;
        logic signed [12:0] tgt;
        logic signed [12:0] cur;
        int                 n;
        logic [3:0]         gates;
        logic               pk;
        logic [2:0]         ph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic signed [12:0] tgt,
                                input logic signed [12:0] cur, input int n,
                                input logic [3:0] g, input logic pk, input logic [2:0] ph);
        vec_t v;
        v.en = en; v.tgt = tgt; v.cur = cur; v.n = n;
        v.gates = g; v.pk = pk; v.ph = ph;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        enable  = v.en;
        target  = v.tgt;
        current = v.cur;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] g,
                               input logic pk, input logic [2:0] ph);
        vectors++;
        if ({high_1, low_1, high_2, low_2} !== g || peak !== pk || phase !== ph) begin
            miscompares++;
            $display("[TB] FAIL %s: got gates=%b peak=%b phase=%0d, expected gates=%b peak=%b phase=%0d",
                     name, {high_1, low_1, high_2, low_2}, peak, phase, g, pk, ph);
        end
    endtask

    // Every stepped cycle is also screened for shoot-through and for a pattern change
    // that skipped the dead time.
    task automatic tick();
        logic [3:0] g;
        @(posedge clk);
        #1;
        g = {high_1, low_1, high_2, low_2};
        vectors++;
        if ((high_1 && low_1) || (high_2 && low_2)) begin
            miscompares++;
            $display("[TB] FAIL shoot_through: got gates=%b, expected no leg with both switches on", g);
        end
        if (g != 4'b0000) begin
            if (last_nz != 4'b0000 && g != last_nz && zero_run < 3) begin
                miscompares++;
                $display("[TB] FAIL deadtime: got %0d zero cycles before %b, expected at least 3", zero_run, g);
            end
            last_nz  = g;
            zero_run = 0;
        end else begin
            zero_run++;
        end
    endtask

    initial begin
        resetn  = 1'b0;
        enable  = 1'b0;
        target  = 13'sd100;
        current = 13'sd0;

        // Idle and forward chop into the first off phase.
        vecs.push_back(mk(1'b0,  13'sd100,  13'sd0,   4, G0,  1'b0, 3'd0));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd0,   3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd0,  10, FWD, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100, 1, G0,  1'b1, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100, 2, G0,  1'b0, 3'd1));
`ifdef HBRIDGE_MIXED_DECAY_EN
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100, 8, REV, 1'b0, 3'd3));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100, 3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100,24, SLW, 1'b0, 3'd4));
`else
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100,32, SLW, 1'b0, 3'd4));
`endif
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd100, 3, G0,  1'b0, 3'd1));
        // Blanking: already above target, ON still lasts exactly 8 cycles.
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd200, 8, FWD, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd200, 1, G0,  1'b1, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd200, 2, G0,  1'b0, 3'd1));
`ifdef HBRIDGE_MIXED_DECAY_EN
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd200, 5, REV, 1'b0, 3'd3));
`else
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd200, 5, SLW, 1'b0, 3'd4));
`endif
        // Disable mid-off, then reverse drive with sign flips during ON.
        vecs.push_back(mk(1'b0,  13'sd100,  13'sd200, 3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b0,  13'sd100,  13'sd200, 2, G0,  1'b0, 3'd0));
        vecs.push_back(mk(1'b1, -13'sd100,  13'sd0,   3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1, -13'sd100,  13'sd0,   8, REV, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd0,   3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd100,  13'sd0,   4, FWD, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, -13'sd100,  13'sd0,   3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1, -13'sd100,  13'sd0,   2, REV, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, -13'sd100, -13'sd100, 6, REV, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, -13'sd100, -13'sd100, 1, G0,  1'b1, 3'd1));
        // Zero target holds in slow decay until a non-zero target returns.
        vecs.push_back(mk(1'b1,  13'sd0,   -13'sd100, 2, G0,  1'b0, 3'd1));
`ifdef HBRIDGE_MIXED_DECAY_EN
        vecs.push_back(mk(1'b1,  13'sd0,   -13'sd100, 8, FWD, 1'b0, 3'd3));
        vecs.push_back(mk(1'b1,  13'sd0,   -13'sd100, 3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1,  13'sd0,   -13'sd100,29, SLW, 1'b0, 3'd4));
`else
        vecs.push_back(mk(1'b1,  13'sd0,   -13'sd100,40, SLW, 1'b0, 3'd4));
`endif
        vecs.push_back(mk(1'b1, -13'sd50,  -13'sd100, 3, G0,  1'b0, 3'd1));
        vecs.push_back(mk(1'b1, -13'sd50,  -13'sd100, 8, REV, 1'b0, 3'd2));
        vecs.push_back(mk(1'b1, -13'sd50,  -13'sd100, 1, G0,  1'b1, 3'd1));

        #1;
        checkOutput("reset_state", G0, 1'b0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            for (int c = 0; c < vecs[i].n; c++) begin
                tick();
                checkOutput($sformatf("vec%0d_cycle%0d", i, c), vecs[i].gates, vecs[i].pk, vecs[i].ph);
            end
        end

        // Flip back to forward from DEAD, then hit the bridge with an async reset while ON.
        enable  = 1'b1;
        target  = 13'sd100;
        current = 13'sd0;
        for (int k = 0; k < 8 && phase != 3'd2; k++) begin
            tick();
        end
        checkOutput("resume_forward", FWD, 1'b0, 3'd2);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset", G0, 1'b0, 3'd0);
        #2;
        resetn = 1'b1;
        tick();
        checkOutput("restart_from_idle", G0, 1'b0, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
